// File: rtl/fc_rx_frame_extract_pkg.sv
// FC ordered-set constants and word classification helpers for the RX frame extractor.
// Only the SOF/EOF codes the extractor must recognise are listed here.
package fc;

  localparam logic [31:0] SOF_I3 = 32'hBCB5_5656;
  localparam logic [31:0] SOF_N3 = 32'hBCB5_3636;
  localparam logic [31:0] SOF_I2 = 32'hBCB5_5555;
  localparam logic [31:0] SOF_N2 = 32'hBCB5_3535;
  localparam logic [31:0] SOF_F  = 32'hBCB5_5858;

  localparam logic [31:0] EOF_T  = 32'hBC95_7575;
  localparam logic [31:0] EOF_N  = 32'hBC95_D5D5;
  localparam logic [31:0] EOF_A  = 32'hBC95_F5F5;
  localparam logic [31:0] EOF_NI = 32'hBC8A_D5D5;

  localparam logic [3:0] K_ORDERED_SET = 4'b1000;
  localparam logic [3:0] K_DATA        = 4'b0000;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    FRAME   = 2'd1,
    DISCARD = 2'd2
  } rx_frame_state_t;

  typedef enum logic [1:0] {
    CLS_OTHER = 2'd0,
    CLS_DATA  = 2'd1,
    CLS_SOF   = 2'd2,
    CLS_EOF   = 2'd3
  } rx_word_class_t;

  function automatic logic is_sof(input logic [31:0] w);
    return (w == SOF_I3) || (w == SOF_N3) || (w == SOF_I2) ||
           (w == SOF_N2) || (w == SOF_F);
  endfunction

  function automatic logic is_eof(input logic [31:0] w);
    return (w == EOF_T) || (w == EOF_N) || (w == EOF_A) || (w == EOF_NI);
  endfunction

  function automatic logic is_eof_abort(input logic [31:0] w);
    return (w == EOF_A);
  endfunction

  // Delimiters must carry K only on the first (most significant) byte.
  function automatic rx_word_class_t classify(input logic        valid,
                                              input logic [3:0]  k,
                                              input logic [31:0] d);
    rx_word_class_t c;
    c = CLS_OTHER;
    if (valid) begin
      if (k == K_DATA) begin
        c = CLS_DATA;
      end else if (k == K_ORDERED_SET) begin
        if (is_sof(d)) begin
          c = CLS_SOF;
        end else if (is_eof(d)) begin
          c = CLS_EOF;
        end
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/fc_rx_frame_extract.sv
// Extracts SOF..EOF frames from the aligned RX word stream into an Avalon-ST packet
// stream; a one-beat hold register lets eop/error be attached to the last beat.
module fc_rx_frame_extract
  import fc::*;
#(
  parameter int MAX_WORDS = 537
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [35:0] rx_data,
  input  logic        rx_valid,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic        out_error,
  output logic        in_frame,
  output logic [31:0] frame_ok_count,
  output logic [31:0] frame_err_count
);

  localparam int              CNT_W   = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

  // Output handshake: out_valid marks a beat that the sink must take in that
  // cycle; there is no ready, and out_error is meaningful only with out_endofpacket.

  logic [35:0]       s1_data_q;
  logic              s1_valid_q;
  rx_word_class_t    word_cls;

  rx_frame_state_t   state_q, state_d;
  logic [31:0]       hold_data_q, hold_data_d;
  logic              hold_sop_q, hold_sop_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              eof_pend_q, eof_pend_d;
  logic [31:0]       eof_data_q, eof_data_d;
  logic              eof_err_q, eof_err_d;

  logic              beat_valid_d;
  logic [31:0]       beat_data_d;
  logic              beat_sop_d;
  logic              beat_eop_d;
  logic              beat_err_d;

  logic [31:0]       out_data_q;
  logic              out_valid_q, out_sop_q, out_eop_q, out_err_q;
  logic [31:0]       ok_cnt_q, err_cnt_q;

  assign word_cls = classify(s1_valid_q, s1_data_q[35:32], s1_data_q[31:0]);

  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_sop_d   = hold_sop_q;
    word_cnt_d   = word_cnt_q;
    eof_pend_d   = 1'b0;
    eof_data_d   = eof_data_q;
    eof_err_d    = eof_err_q;
    beat_valid_d = 1'b0;
    beat_data_d  = '0;
    beat_sop_d   = 1'b0;
    beat_eop_d   = 1'b0;
    beat_err_d   = 1'b0;

    // The EOF beat trails its predecessor by one cycle; the FSM is back in HUNT then.
    if (eof_pend_q) begin
      beat_valid_d = 1'b1;
      beat_data_d  = eof_data_q;
      beat_eop_d   = 1'b1;
      beat_err_d   = eof_err_q;
    end

    case (state_q)
      HUNT, DISCARD: begin
        if (word_cls == CLS_SOF) begin
          state_d     = FRAME;
          hold_data_d = s1_data_q[31:0];
          hold_sop_d  = 1'b1;
          word_cnt_d  = CNT_W'(1);
        end else if ((state_q == DISCARD) && (word_cls == CLS_EOF)) begin
          state_d = HUNT;
        end
      end

      FRAME: begin
        // Every word seen inside a frame releases the held beat in some form.
        beat_valid_d = 1'b1;
        beat_data_d  = hold_data_q;
        beat_sop_d   = hold_sop_q;
        beat_eop_d   = 1'b0;
        beat_err_d   = 1'b0;
        case (word_cls)
          CLS_DATA: begin
            if (word_cnt_q == CNT_MAX) begin
              beat_eop_d = 1'b1;
              beat_err_d = 1'b1;
              state_d    = DISCARD;
            end else begin
              hold_data_d = s1_data_q[31:0];
              hold_sop_d  = 1'b0;
              word_cnt_d  = word_cnt_q + 1'b1;
            end
          end
          CLS_EOF: begin
            state_d = HUNT;
            if (word_cnt_q == CNT_MAX) begin
              beat_eop_d = 1'b1;
              beat_err_d = 1'b1;
            end else begin
              eof_pend_d = 1'b1;
              eof_data_d = s1_data_q[31:0];
              eof_err_d  = is_eof_abort(s1_data_q[31:0]);
            end
          end
          CLS_SOF: begin
            beat_eop_d  = 1'b1;
            beat_err_d  = 1'b1;
            hold_data_d = s1_data_q[31:0];
            hold_sop_d  = 1'b1;
            word_cnt_d  = CNT_W'(1);
          end
          default: begin
            beat_eop_d = 1'b1;
            beat_err_d = 1'b1;
            state_d    = HUNT;
          end
        endcase
      end

      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_data_q   <= '0;
      s1_valid_q  <= 1'b0;
      state_q     <= HUNT;
      hold_data_q <= '0;
      hold_sop_q  <= 1'b0;
      word_cnt_q  <= '0;
      eof_pend_q  <= 1'b0;
      eof_data_q  <= '0;
      eof_err_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
      ok_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      s1_data_q   <= rx_data;
      s1_valid_q  <= rx_valid;
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_sop_q  <= hold_sop_d;
      word_cnt_q  <= word_cnt_d;
      eof_pend_q  <= eof_pend_d;
      eof_data_q  <= eof_data_d;
      eof_err_q   <= eof_err_d;
      out_valid_q <= beat_valid_d;
      out_data_q  <= beat_data_d;
      out_sop_q   <= beat_sop_d;
      out_eop_q   <= beat_eop_d;
      out_err_q   <= beat_err_d;
      if (beat_valid_d && beat_eop_d) begin
        if (beat_err_d) begin
          err_cnt_q <= err_cnt_q + 32'd1;
        end else begin
          ok_cnt_q <= ok_cnt_q + 32'd1;
        end
      end
    end
  end

  assign out_data          = out_data_q;
  assign out_valid         = out_valid_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_error         = out_err_q;
  assign in_frame          = (state_q == FRAME);
  assign frame_ok_count    = ok_cnt_q;
  assign frame_err_count   = err_cnt_q;

endmodule

// File: tb/tb_fc_rx_frame_extract.sv
// Bench for fc_rx_frame_extract: directed frames plus random word streams, checked
// against a frame-level reference model through an expected-beat queue.
module tb_fc_rx_frame_extract;

  localparam int MAX_WORDS = 537;

  localparam logic [31:0] T_SOF_I3 = 32'hBCB55656;
  localparam logic [31:0] T_SOF_N3 = 32'hBCB53636;
  localparam logic [31:0] T_SOF_I2 = 32'hBCB55555;
  localparam logic [31:0] T_SOF_N2 = 32'hBCB53535;
  localparam logic [31:0] T_SOF_F  = 32'hBCB55858;
  localparam logic [31:0] T_EOF_T  = 32'hBC957575;
  localparam logic [31:0] T_EOF_N  = 32'hBC95D5D5;
  localparam logic [31:0] T_EOF_A  = 32'hBC95F5F5;
  localparam logic [31:0] T_EOF_NI = 32'hBC8AD5D5;
  localparam logic [31:0] T_IDLE   = 32'hBC95B5B5;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [35:0] rx_data;
  logic        rx_valid;
  logic [31:0] out_data;
  logic        out_valid, out_startofpacket, out_endofpacket, out_error, in_frame;
  logic [31:0] frame_ok_count, frame_err_count;

  fc_rx_frame_extract #(.MAX_WORDS(MAX_WORDS)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_error         (out_error),
    .in_frame          (in_frame),
    .frame_ok_count    (frame_ok_count),
    .frame_err_count   (frame_err_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: beats packed as {data, sop, eop, error}
  logic [34:0] exp_q[$];
  logic [34:0] obs_q[$];

  // reference model state
  logic [31:0] frm_q[$];
  bit          m_in_frame;
  bit          m_discard;
  int unsigned m_ok, m_err;

  // word sampled by the DUT but not yet acted upon
  bit          pend_v;
  logic        pend_valid;
  logic [35:0] pend_word;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int classify_word(input logic v, input logic [35:0] w);
    if (!v) return 0;
    if (w[35:32] == 4'b0000) return 1;
    if (w[35:32] == 4'b1000) begin
      if (w[31:0] inside {T_SOF_I3, T_SOF_N3, T_SOF_I2, T_SOF_N2, T_SOF_F}) return 2;
      if (w[31:0] inside {T_EOF_T, T_EOF_N, T_EOF_A, T_EOF_NI}) return 3;
    end
    return 0;
  endfunction

  task automatic emit_frame(input bit err);
    int n;
    n = frm_q.size();
    for (int i = 0; i < n; i++) begin
      logic last;
      last = (i == n - 1);
      exp_q.push_back({frm_q[i], 1'(i == 0), last, last & err});
    end
    if (err) m_err++;
    else m_ok++;
    frm_q.delete();
    m_in_frame = 0;
  endtask

  task automatic start_frame(input logic [31:0] sof);
    frm_q.delete();
    frm_q.push_back(sof);
    m_in_frame = 1;
  endtask

  task automatic model_push(input logic v, input logic [35:0] w);
    int c;
    c = classify_word(v, w);
    if (m_discard) begin
      if (c == 3) m_discard = 0;
      else if (c == 2) begin
        m_discard = 0;
        start_frame(w[31:0]);
      end
    end else if (!m_in_frame) begin
      if (c == 2) start_frame(w[31:0]);
    end else begin
      case (c)
        1: begin
          if (frm_q.size() == MAX_WORDS) begin
            emit_frame(1);
            m_discard = 1;
          end else frm_q.push_back(w[31:0]);
        end
        3: begin
          if (frm_q.size() == MAX_WORDS) emit_frame(1);
          else begin
            frm_q.push_back(w[31:0]);
            emit_frame(w[31:0] == T_EOF_A);
          end
        end
        2: begin
          emit_frame(1);
          start_frame(w[31:0]);
        end
        default: emit_frame(1);
      endcase
    end
  endtask

  // A reset mid-frame loses the last accepted word; everything before it already left.
  task automatic model_reset();
    if (m_in_frame) begin
      for (int i = 0; i < frm_q.size() - 1; i++)
        exp_q.push_back({frm_q[i], 1'(i == 0), 1'b0, 1'b0});
    end
    frm_q.delete();
    m_in_frame = 0;
    m_discard  = 0;
    m_ok       = 0;
    m_err      = 0;
  endtask

  // driver tasks
  task automatic drive_word(input logic v, input logic [35:0] w);
    rx_valid = v;
    rx_data  = w;
    @(posedge clk);
    if (pend_v) model_push(pend_valid, pend_word);
    pend_v     = 1;
    pend_valid = v;
    pend_word  = w;
    #1;
    check("in_frame", in_frame, m_in_frame);
  endtask

  task automatic drive_k(input logic [31:0] d);
    drive_word(1'b1, {4'b1000, d});
  endtask

  task automatic drive_d(input logic [31:0] d);
    drive_word(1'b1, {4'b0000, d});
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = '0;
    reset_n  = 1'b0;
    @(posedge clk);
    model_reset();
    pend_v = 0;
    @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_sop", out_startofpacket, 0);
    check("rst_eop", out_endofpacket, 0);
    check("rst_err", out_error, 0);
    check("rst_data", out_data, 0);
    check("rst_in_frame", in_frame, 0);
    check("rst_ok_cnt", frame_ok_count, 0);
    check("rst_err_cnt", frame_err_count, 0);
    reset_n = 1'b1;
  endtask

  task automatic finish_phase(input string tag);
    int n;
    repeat (4) drive_k(T_IDLE);
    check({tag, "/beats"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s/beat%0d", tag, i), obs_q[i], exp_q[i]);
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, "/ok_cnt"}, frame_ok_count, m_ok);
    check({tag, "/err_cnt"}, frame_err_count, m_err);
  endtask

  task automatic drive_random();
    int r;
    r = $urandom_range(0, 99);
    if (r < 8) begin
      case ($urandom_range(0, 4))
        0: drive_k(T_SOF_I3);
        1: drive_k(T_SOF_N3);
        2: drive_k(T_SOF_I2);
        3: drive_k(T_SOF_N2);
        default: drive_k(T_SOF_F);
      endcase
    end else if (r < 14) begin
      case ($urandom_range(0, 3))
        0: drive_k(T_EOF_T);
        1: drive_k(T_EOF_N);
        2: drive_k(T_EOF_A);
        default: drive_k(T_EOF_NI);
      endcase
    end else if (r < 17) begin
      drive_k(T_IDLE);
    end else if (r < 19) begin
      drive_word(1'b0, {4'b0000, $urandom()});
    end else if (r < 21) begin
      logic [3:0] k;
      k = 4'($urandom_range(1, 15));
      drive_word(1'b1, {k, $urandom()});
    end else begin
      drive_d($urandom());
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      obs_q.push_back({out_data, out_startofpacket, out_endofpacket, out_error});
      check("err_without_eop", out_error & ~out_endofpacket, 0);
    end
  end

  initial begin
    pend_v     = 0;
    m_in_frame = 0;
    m_discard  = 0;
    m_ok       = 0;
    m_err      = 0;
    reset_n    = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = '0;

    // 1: good frame
    do_reset();
    drive_k(T_SOF_I3);
    for (int i = 1; i <= 6; i++) drive_d(32'(i));
    drive_k(T_EOF_T);
    finish_phase("t1_eoft");

    // 2: aborted frame
    do_reset();
    drive_k(T_SOF_I3);
    for (int i = 1; i <= 6; i++) drive_d(32'(i));
    drive_k(T_EOF_A);
    finish_phase("t2_eofa");

    // 3: fill word inside a frame, then stray data
    do_reset();
    drive_k(T_SOF_I3);
    for (int i = 1; i <= 3; i++) drive_d(32'h100 + 32'(i));
    drive_k(T_IDLE);
    for (int i = 1; i <= 3; i++) drive_d(32'h200 + 32'(i));
    finish_phase("t3_idle");

    // 4: SOF inside a frame
    do_reset();
    drive_k(T_SOF_I3);
    drive_d(32'hA1);
    drive_d(32'hA2);
    drive_k(T_SOF_N3);
    drive_d(32'hB1);
    drive_k(T_EOF_N);
    finish_phase("t4_sof_sof");

    // 5: oversize frame
    do_reset();
    drive_k(T_SOF_I2);
    for (int i = 1; i <= 540; i++) drive_d(32'(i));
    drive_k(T_EOF_T);
    finish_phase("t5_oversize");

    // 6: valid gap mid-frame, then reset mid-frame
    do_reset();
    drive_k(T_SOF_F);
    for (int i = 1; i <= 3; i++) drive_d(32'h300 + 32'(i));
    drive_word(1'b0, 36'h0);
    drive_d(32'h3F0);
    drive_d(32'h3F1);
    drive_k(T_SOF_N2);
    for (int i = 1; i <= 5; i++) drive_d(32'h400 + 32'(i));
    do_reset();
    finish_phase("t6_reset");

    // random streams
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 250; i++) drive_random();
      finish_phase($sformatf("rand%0d", p));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
